// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one byte at a time from NUM_REQ requesters into a UART transmitter.
// Define UART_ARB_PRIO_EN to replace round-robin with fixed priority (lowest index wins).
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_BITS   = 8,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           ack,
    output logic                         tx_start,
    output logic [DATA_BITS-1:0]         tx_data,
    input  logic                         tx_done,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic                         timeout_err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam bit TO_EN = (TIMEOUT_CYC > 0);
    localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT_CYC - 1 : 0);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
    if (DATA_BITS < 1) begin : g_bad_data_bits
        $error("uart_tx_arbiter: DATA_BITS must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t               state;
    logic [ID_W-1:0]      ptr;
    logic [CNT_W-1:0]     cnt;
    logic [ID_W-1:0]      winner;
    logic [ID_W-1:0]      next_ptr;
    logic [DATA_BITS-1:0] sel_data;

`ifdef UART_ARB_PRIO_EN
    // Fixed priority: scanning downward lets the lowest set index overwrite the others.
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[ID_W'(i)]) winner = ID_W'(i);
        end
    end

    assign next_ptr = '0;
`else
    logic found;

    // NOTE: every variable gets a default before the loop; otherwise a latch is inferred.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[ID_W'(idx)]) begin
                winner = ID_W'(idx);
                found  = 1'b1;
            end
        end
    end

    assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
`endif

    assign sel_data = req_data[winner*DATA_BITS +: DATA_BITS];

    // NOTE: state is assigned with <= so every branch sees the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            cnt         <= '0;
            ack         <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ack         <= '0;
            tx_start    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        state    <= ST_START;
                        busy     <= 1'b1;
                        tx_data  <= sel_data;
                        grant_id <= winner;
                        ack      <= NUM_REQ'(1) << winner;
                        tx_start <= 1'b1;
                    end
                end
                ST_START: begin
                    state <= ST_WAIT;
                    cnt   <= '0;
                end
                ST_WAIT: begin
                    // tx_done is tested first so it wins over a coincident timeout.
                    if (tx_done) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        ptr   <= next_ptr;
                    end else if (TO_EN && cnt == CNT_LAST) begin
                        state       <= ST_IDLE;
                        busy        <= 1'b0;
                        ptr         <= next_ptr;
                        timeout_err <= 1'b1;
                    end else if (TO_EN) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table of single frames plus hand-written
// sequences for round-robin order, timeout, tx_done corner cases, reset and a UART loopback.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int DB = 8;
    localparam int TO = 16;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic [NR-1:0] req      = '0;
    logic [31:0]   req_data = '0;
    logic          tb_done  = 1'b0;
    logic          loop_en  = 1'b0;
    logic          tx_done;
    logic [NR-1:0] ack;
    logic          tx_start;
    logic [DB-1:0] tx_data;
    logic [1:0]    grant_id;
    logic          busy;
    logic          timeout_err;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_arbiter #(
        .NUM_REQ    (NR),
        .DATA_BITS  (DB),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Serial transmitter/receiver models for the loopback test: 1 clock per bit, 8N1.
    logic       uart_done;
    logic       ser;
    logic [9:0] m_sh;
    logic [3:0] m_cnt;
    logic       m_pend;
    logic       r_act;
    logic [3:0] r_n;
    logic [7:0] r_sh;
    logic [7:0] rx_byte [4];
    int         rx_cnt;

    assign tx_done = loop_en ? uart_done : tb_done;

    always @(posedge clk) begin
        if (!loop_en) begin
            m_cnt     <= '0;
            m_pend    <= 1'b0;
            ser       <= 1'b1;
            uart_done <= 1'b0;
        end else begin
            uart_done <= 1'b0;
            if (tx_start) begin
                m_sh   <= {1'b1, tx_data, 1'b0};
                m_cnt  <= 4'd10;
                m_pend <= 1'b1;
            end else if (m_cnt != 0) begin
                ser   <= m_sh[0];
                m_sh  <= m_sh >> 1;
                m_cnt <= m_cnt - 4'd1;
            end else if (m_pend) begin
                uart_done <= 1'b1;
                m_pend    <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (!loop_en) begin
            r_act  <= 1'b0;
            r_n    <= '0;
            rx_cnt <= 0;
        end else if (!r_act) begin
            if (ser == 1'b0) begin
                r_act <= 1'b1;
                r_n   <= '0;
            end
        end else if (r_n < 4'd8) begin
            r_sh <= {ser, r_sh[7:1]};
            r_n  <= r_n + 4'd1;
        end else begin
            r_act <= 1'b0;
            if (ser && rx_cnt < 4) begin
                rx_byte[rx_cnt] <= r_sh;
                rx_cnt          <= rx_cnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        req     = '0;
        tb_done = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [1:0]  exp_w;
        logic [7:0]  exp_d;
    } vec_t;

    vec_t       vecs [8];
    logic [1:0] order [4];

    initial begin
        int n;

        vecs[0] = '{4'b0010, 32'hD3C2A5B0, 2'd1, 8'hA5};
        vecs[1] = '{4'b0011, 32'h11223344, 2'd0, 8'h44};
`ifdef UART_ARB_PRIO_EN
        vecs[2] = '{4'b1001, 32'h55667788, 2'd0, 8'h88};
`else
        vecs[2] = '{4'b1001, 32'h55667788, 2'd3, 8'h55};
`endif
        vecs[3] = '{4'b1000, 32'h9ABCDEF0, 2'd3, 8'h9A};
        vecs[4] = '{4'b1000, 32'h0F1E2D3C, 2'd3, 8'h0F};
        vecs[5] = '{4'b0110, 32'hCAFEBABE, 2'd1, 8'hBA};
`ifdef UART_ARB_PRIO_EN
        vecs[6] = '{4'b0110, 32'hDEADBEEF, 2'd1, 8'hBE};
        order   = '{2'd0, 2'd0, 2'd0, 2'd0};
`else
        vecs[6] = '{4'b0110, 32'hDEADBEEF, 2'd2, 8'hAD};
        order   = '{2'd0, 2'd1, 2'd2, 2'd3};
`endif
        vecs[7] = '{4'b0101, 32'h01234567, 2'd0, 8'h67};

        // Reset values while rst_n is held low.
        rst_n = 1'b0;
        repeat (2) tick();
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_tx_start", 32'(tx_start), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_grant_id", 32'(grant_id), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_timeout_err", 32'(timeout_err), 32'h0);
        rst_n = 1'b1;

        // Single frames, pointer carried from one vector to the next.
        for (int i = 0; i < 8; i++) begin
            req      = vecs[i].req;
            req_data = vecs[i].data;
            tick();
            check($sformatf("v%0d_ack", i), 32'(ack), 32'(4'b0001 << vecs[i].exp_w));
            check($sformatf("v%0d_tx_start", i), 32'(tx_start), 32'h1);
            check($sformatf("v%0d_tx_data", i), 32'(tx_data), 32'(vecs[i].exp_d));
            check($sformatf("v%0d_grant_id", i), 32'(grant_id), 32'(vecs[i].exp_w));
            check($sformatf("v%0d_busy", i), 32'(busy), 32'h1);
            req = '0;
            tick();
            check($sformatf("v%0d_start_pulse", i), 32'({ack, tx_start}), 32'h0);
            repeat (3) tick();
            check($sformatf("v%0d_busy_wait", i), 32'(busy), 32'h1);
            check($sformatf("v%0d_data_hold", i), 32'(tx_data), 32'(vecs[i].exp_d));
            tb_done = 1'b1;
            tick();
            tb_done = 1'b0;
            check($sformatf("v%0d_idle", i), 32'(busy), 32'h0);
        end

        // All four requesting continuously from pointer 0.
        do_reset();
        req      = 4'b1111;
        req_data = 32'h44332211;
        for (int f = 0; f < 4; f++) begin
            tick();
            check($sformatf("rr%0d_grant_id", f), 32'(grant_id), 32'(order[f]));
            check($sformatf("rr%0d_tx_start", f), 32'(tx_start), 32'h1);
            repeat (2) tick();
            tb_done = 1'b1;
            tick();
            tb_done = 1'b0;
            if (f == 3) req = '0;
            check($sformatf("rr%0d_idle", f), 32'(busy), 32'h0);
        end

        // Timeout: tx_done never arrives.
        req      = 4'b0100;
        req_data = 32'h00770000;
        tick();
        check("to_grant_id", 32'(grant_id), 32'd2);
        req = '0;
        tick();
        n = 0;
        do begin
            tick();
            n++;
        end while (!timeout_err && n < 40);
        check("to_latency", 32'(n), 32'd16);
        check("to_pulse", 32'(timeout_err), 32'h1);
        check("to_idle", 32'(busy), 32'h0);
        req = 4'b1111;
        tick();
        check("to_pulse_end", 32'(timeout_err), 32'h0);
`ifdef UART_ARB_PRIO_EN
        check("to_next_winner", 32'(grant_id), 32'd0);
`else
        check("to_next_winner", 32'(grant_id), 32'd3);
`endif
        req = '0;
        tick();
        tb_done = 1'b1;
        tick();
        tb_done = 1'b0;

        // tx_done in IDLE and START is ignored; tx_done beats a coincident timeout.
        tb_done = 1'b1;
        tick();
        tb_done = 1'b0;
        check("done_in_idle", 32'({busy, tx_start}), 32'h0);
        req = 4'b0001;
        tick();
        check("dis_tx_start", 32'(tx_start), 32'h1);
        tb_done = 1'b1;
        req     = '0;
        tick();
        tb_done = 1'b0;
        check("done_in_start", 32'(busy), 32'h1);
        repeat (15) tick();
        check("dis_still_wait", 32'(busy), 32'h1);
        tb_done = 1'b1;
        tick();
        tb_done = 1'b0;
        check("done_vs_timeout_err", 32'(timeout_err), 32'h0);
        check("done_vs_timeout_idle", 32'(busy), 32'h0);
        tick();
        check("done_vs_timeout_late", 32'(timeout_err), 32'h0);

        // Asynchronous reset in WAIT, then a pending request after release.
        req      = 4'b0100;
        req_data = 32'h005A0033;
        tick();
        req = '0;
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ack", 32'(ack), 32'h0);
        check("arst_tx_start", 32'(tx_start), 32'h0);
        check("arst_tx_data", 32'(tx_data), 32'h0);
        check("arst_grant_id", 32'(grant_id), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_timeout_err", 32'(timeout_err), 32'h0);
        req = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("arst_first_ack", 32'(ack), 32'h1);
        check("arst_first_grant", 32'(grant_id), 32'h0);
        check("arst_first_data", 32'(tx_data), 32'h33);
        req = '0;
        tick();
        tb_done = 1'b1;
        tick();
        tb_done = 1'b0;

        // Loopback through the serial models.
        do_reset();
        loop_en  = 1'b1;
        req_data = 32'h0000FE01;
        req      = 4'b0011;
        n = 0;
        do begin
            tick();
            n++;
        end while (ack !== 4'b0001 && n < 20);
        check("lb_ack0", 32'(ack), 32'h1);
        req = 4'b0010;
        n = 0;
        do begin
            tick();
            n++;
        end while (ack !== 4'b0010 && n < 40);
        check("lb_ack1", 32'(ack), 32'h2);
        req = '0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(rx_cnt == 2 && !busy) && n < 60);
        check("lb_rx_count", 32'(rx_cnt), 32'd2);
        check("lb_byte0", 32'(rx_byte[0]), 32'h01);
        check("lb_byte1", 32'(rx_byte[1]), 32'hFE);
        loop_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters; legal range 2..8.
REQ-002 Parameter DATA_BITS, default 8, SHALL set the byte width; it SHALL match the transmitter's data width.
REQ-003 Parameter TIMEOUT_CYC, default 1023, SHALL set the maximum cycles to wait for tx_done; 0 disables the timeout.
REQ-004 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  NUM_REQ  per-requester transmit request, level.
REQ-007 req_data  input  NUM_REQ*DATA_BITS  per-requester byte; requester i occupies bits [i*DATA_BITS +: DATA_BITS].
REQ-008 ack  output  NUM_REQ  one-cycle pulse: byte of requester i accepted.
REQ-009 tx_start  output  1  one-cycle start strobe to the UART transmitter.
REQ-010 tx_data  output  DATA_BITS  byte to the transmitter, held stable from START until the next grant.
REQ-011 tx_done  input  1  transmitter frame-complete pulse.
REQ-012 grant_id  output  clog2(NUM_REQ)  index of the current or last winner.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 timeout_err  output  1  one-cycle pulse when a frame is abandoned on timeout.

Function
REQ-015 FSM states SHALL be IDLE, START and WAIT; all outputs SHALL be registered.
REQ-016 In IDLE with req nonzero at a rising edge, the arbiter SHALL select winner w, latch req_data for w into tx_data, set grant_id=w, and enter START.
REQ-017 In START, ack[w]=1 and tx_start=1 SHALL be asserted for exactly one cycle, and the next state SHALL be WAIT.
REQ-018 In WAIT, tx_done=1 SHALL return the FSM to IDLE and set the round-robin pointer to (w+1) mod NUM_REQ.
REQ-019 Round-robin: the winner SHALL be the first set req bit at or after the pointer, searching upward with wrap-around.
REQ-020 Request-to-tx_start latency SHALL be exactly 1 cycle; the minimum spacing between successive tx_start pulses SHALL be the frame time plus 2 cycles.
REQ-021 req SHALL be sampled only in IDLE; a req dropped before its ack is never served, and req changes in START or WAIT are ignored.
REQ-022 A requester that still holds req after its ack SHALL be treated as requesting another byte.
REQ-023 tx_done in IDLE or START SHALL be ignored.
REQ-024 The WAIT cycle counter SHALL start at 0 on entry; when TIMEOUT_CYC>0 and the count reaches TIMEOUT_CYC without tx_done, the block SHALL pulse timeout_err, advance the pointer as in REQ-018, and enter IDLE.
REQ-025 If tx_done and the timeout occur in the same cycle, tx_done SHALL win and timeout_err SHALL stay 0.
REQ-026 With a single active requester, that requester SHALL be served on every arbitration.

Reset
REQ-027 With rst_n=0, the block SHALL immediately force state=IDLE, pointer=0, counter=0, ack=0, tx_start=0, timeout_err=0, busy=0, tx_data=0 and grant_id=0, independent of clk.
REQ-028 A reset during START or WAIT SHALL abandon the frame without an ack.
REQ-029 The first arbitration SHALL occur on the first rising edge after rst_n deasserts.

Configuration
REQ-030 When UART_ARB_PRIO_EN is defined, REQ-019 SHALL be replaced by fixed priority: the lowest set index wins, and the pointer is unused and remains 0.
REQ-031 When UART_ARB_PRIO_EN is undefined, round-robin per REQ-019 SHALL apply; all other behaviour SHALL be identical in both builds.

Verification
REQ-032 Reset, then req=4'b0010 with data1=8'hA5 -> 1 cycle later ack=4'b0010, tx_start=1, tx_data=8'hA5, grant_id=1; busy stays high until tx_done.
REQ-033 req=4'b1111 held for 4 frames, pointer starting at 0 -> grant order 0,1,2,3; with UART_ARB_PRIO_EN defined -> 0,0,0,0.
REQ-034 tx_done held low, TIMEOUT_CYC=16 -> timeout_err pulses once 16 cycles after WAIT entry; the FSM returns to IDLE and the next winner is w+1.
REQ-035 rst_n pulsed low during WAIT -> all outputs are 0 asynchronously; after release, a pending req=4'b0001 is granted with pointer 0.
REQ-036 tx_done pulsed in IDLE and START -> no state change; tx_done and the timeout in the same cycle -> timeout_err=0.
REQ-037 Loopback with the UART RX/TX pair (8 data bits, 1 clock per bit), two requesters sending 8'h01 and 8'hFE -> the receiver outputs 8'h01 then 8'hFE.
